// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave: oversampled serial lines, RX FIFO, TX hold register, req/ack register port
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss,
    output logic                  miso
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);

    localparam logic [1:0] ADDR_CFG = 2'd0;
    localparam logic [1:0] ADDR_TX  = 2'd1;
    localparam logic [1:0] ADDR_RX  = 2'd2;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_d, ss_d;
    logic                   sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge, ss_rise, ss_fall;

    logic [2:0]             cfg_reg, cfg_act;
    logic                   act_dir, act_cpol, act_cpha;
    logic [DATA_WIDTH-1:0]  tx_hold, tx_shift, rx_shift, rx_next;
    logic                   tx_valid, overrun, underrun, skip_shift;
    logic [BIT_W-1:0]       bit_cnt;

    logic                   start, sample_en, shift_en, word_done, load_tx;
    logic                   do_acc, wr_acc, rd_acc, pop, push, stat_clr;

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       cnt;
    logic                   rx_empty, rx_full;
    logic [4:0]             status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];

    assign act_dir  = cfg_act[0];
    assign act_cpol = cfg_act[1];
    assign act_cpha = cfg_act[2];

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign sclk_rise   = sclk_s & ~sclk_d;
    assign sclk_fall   = ~sclk_s & sclk_d;
    assign lead_edge   = act_cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = act_cpol ? sclk_rise : sclk_fall;
    assign sample_edge = act_cpha ? trail_edge : lead_edge;
    assign shift_edge  = act_cpha ? lead_edge : trail_edge;
    assign ss_rise     = ss_s & ~ss_d;
    assign ss_fall     = ~ss_s & ss_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        sample_en  = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_rise) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_fall) begin
                    state_next = IDLE;
                end else begin
                    sample_en = sample_edge;
                    shift_en  = shift_edge;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_next   = act_dir ? {rx_shift[DATA_WIDTH-2:0], mosi_s}
                               : {mosi_s, rx_shift[DATA_WIDTH-1:1]};
    assign word_done = sample_en && (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign load_tx   = start | word_done;
    assign miso      = (state == ACTIVE) && (act_dir ? tx_shift[DATA_WIDTH-1] : tx_shift[0]);

    // After a load the next shift edge must leave the first out bit in place: always after a
    // completed word, and on entry only when cpha=1 (the first leading edge precedes any sample).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_act    <= '0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            skip_shift <= 1'b0;
        end else begin
            if (start) begin
                cfg_act  <= cfg_reg;
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sample_en) begin
                rx_shift <= rx_next;
                bit_cnt  <= word_done ? '0 : bit_cnt + BIT_W'(1);
            end

            if (load_tx) begin
                tx_shift <= tx_valid ? tx_hold : '0;
            end else if (shift_en && !skip_shift) begin
                tx_shift <= act_dir ? {tx_shift[DATA_WIDTH-2:0], 1'b0}
                                    : {1'b0, tx_shift[DATA_WIDTH-1:1]};
            end

            if (start) begin
                skip_shift <= cfg_reg[2];
            end else if (word_done) begin
                skip_shift <= 1'b1;
            end else if (shift_en) begin
                skip_shift <= 1'b0;
            end
        end
    end

    assign do_acc   = req & ~ack;
    assign wr_acc   = do_acc & wr;
    assign rd_acc   = do_acc & ~wr;
    assign pop      = rd_acc && (address == ADDR_RX) && !rx_empty;
    assign push     = word_done && (!rx_full || pop);
    assign stat_clr = rd_acc && (address == 2'd3);
    assign rx_empty = (cnt == '0);
    assign rx_full  = (cnt == CNT_W'(FIFO_DEPTH));
    assign status   = {overrun, underrun, tx_valid, rx_full, rx_empty};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // A host TX write landing on a load cycle wins: the load takes the old word, the new one stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack      <= 1'b0;
            data_out <= '0;
            cfg_reg  <= '0;
            tx_hold  <= '0;
            tx_valid <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            ack <= do_acc;

            if (wr_acc && address == ADDR_CFG) begin
                cfg_reg <= data_in[2:0];
            end

            if (wr_acc && address == ADDR_TX) begin
                tx_hold  <= data_in;
                tx_valid <= 1'b1;
            end else if (load_tx) begin
                tx_valid <= 1'b0;
            end

            overrun  <= (word_done && rx_full && !pop) || (overrun && !stat_clr);
            underrun <= (load_tx && !tx_valid) || (underrun && !stat_clr);

            if (rd_acc) begin
                case (address)
                    ADDR_CFG: data_out <= DATA_WIDTH'(cfg_reg);
                    ADDR_TX:  data_out <= tx_hold;
                    ADDR_RX:  data_out <= rx_empty ? '0 : mem[rd_ptr];
                    default:  data_out <= DATA_WIDTH'(status);
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave against a word-level behavioural model
module tb_spi_slave;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic [1:0] address = 2'd0;
    logic [7:0] data_in = 8'h00;
    logic       ack;
    logic [7:0] data_out;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss = 1'b0;
    logic       miso;

    spi_slave #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .address(address),
        .data_in(data_in), .ack(ack), .data_out(data_out),
        .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [2:0] m_cfg;
    logic [7:0] m_tx_hold;
    bit         m_txv, m_ovr, m_unr;
    logic [7:0] m_fifo[$];

    bit         pending = 1'b0;
    bit         exp_rd = 1'b0;
    logic [7:0] exp_q = 8'h00;
    string      exp_name = "";
    logic [7:0] q;
    logic [7:0] mw [8];
    logic [7:0] got_w [8];
    logic [7:0] stream = 8'h00;
    int         ss_low = 0;
    bit         ack_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic void m_reset();
        m_cfg = 3'b000; m_tx_hold = 8'h00; m_txv = 0; m_ovr = 0; m_unr = 0;
        m_fifo.delete();
    endfunction

    function automatic logic [7:0] m_load();
        logic [7:0] v;
        v = m_txv ? m_tx_hold : 8'h00;
        if (!m_txv) m_unr = 1;
        m_txv = 0;
        return v;
    endfunction

    function automatic logic [7:0] m_status();
        return {3'b000, m_ovr, m_unr, m_txv, m_fifo.size() == DEPTH, m_fifo.size() == 0};
    endfunction

    always @(negedge clk) begin
        if (!rst_n || ss) ss_low = 0;
        else ss_low++;
        if (ss_low > SYNC + 2) check("miso_idle", miso, 0);
        if (rst_n && ack) begin
            check("ack_one_cycle", ack_prev, 0);
            check("ack_requested", pending, 1);
            if (exp_rd) check(exp_name, data_out, exp_q);
        end
        ack_prev = ack;
    end

    task automatic host(input logic w, input logic [1:0] a, input logic [7:0] d, input string name);
        int t;
        t = 0;
        exp_rd = !w;
        exp_name = name;
        if (!w) begin
            case (a)
                2'd0: exp_q = {5'b00000, m_cfg};
                2'd1: exp_q = m_tx_hold;
                2'd2: begin
                    if (m_fifo.size() > 0) exp_q = m_fifo.pop_front();
                    else exp_q = 8'h00;
                end
                default: begin
                    exp_q = m_status();
                    m_ovr = 0;
                    m_unr = 0;
                end
            endcase
        end else if (a == 2'd0) begin
            m_cfg = d[2:0];
        end else if (a == 2'd1) begin
            m_tx_hold = d;
            m_txv = 1;
        end
        @(posedge clk); #1;
        req = 1'b1; wr = w; address = a; data_in = d; pending = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!ack && t < 16);
        if (!ack) begin
            n_chk++;
            $display("FAIL %s: no ack within 16 cycles", name);
        end
        q = data_out;
        @(posedge clk); #1;
        req = 1'b0; pending = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string name);
        host(1'b0, a, 8'h00, name);
    endtask

    task automatic wrr(input logic [1:0] a, input logic [7:0] d);
        host(1'b1, a, d, "write");
    endtask

    // Master side: nw words from mw[], the last one cut short after 'cut' bits when cut > 0.
    task automatic spi_run(input int nw, input int cut);
        logic [7:0] sw, got;
        int nb, idx;
        bit dir, cpol, cpha;
        dir = m_cfg[0]; cpol = m_cfg[1]; cpha = m_cfg[2];
        sclk = cpol; mosi = 1'b0;
        repeat (4) @(posedge clk);
        ss = 1'b1;
        repeat (8) @(posedge clk);
        for (int w = 0; w < nw; w++) begin
            sw = m_load();
            nb = (cut > 0 && w == nw - 1) ? cut : W;
            got = 8'h00;
            for (int i = 0; i < nb; i++) begin
                idx = dir ? W - 1 - i : i;
                if (cpha) sclk = ~sclk;
                mosi = mw[w][idx];
                repeat (HALF) @(posedge clk);
                @(negedge clk);
                got[idx] = miso;
                stream = {stream[6:0], miso};
                check("miso_bit", miso, sw[idx]);
                sclk = ~sclk;
                repeat (HALF) @(posedge clk);
                if (!cpha) sclk = ~sclk;
            end
            got_w[w] = got;
            if (nb == W) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(mw[w]);
                else m_ovr = 1;
            end
        end
        if (cut == 0) void'(m_load());
        repeat (HALF) @(posedge clk);
        ss = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_data_out", data_out, 0);
        check("rst_miso", miso, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(2'd3, "rst_status");
        check("rst_status_lit", q, 8'h01);

        wrr(2'd0, 8'h00);
        wrr(2'd1, 8'hA5);
        mw[0] = 8'h3C;
        spi_run(1, 0);
        check("mode0_miso_stream", stream, 8'hA5);
        rd(2'd2, "mode0_rx");
        check("mode0_rx_lit", q, 8'h3C);
        rd(2'd3, "mode0_status");
        check("mode0_txv_lit", q[2], 0);

        for (int m = 0; m < 4; m++) begin
            wrr(2'd0, 8'(m * 2 + 1));
            wrr(2'd1, 8'h7E);
            mw[0] = 8'h81;
            spi_run(1, 0);
            check("modes_master_rx", got_w[0], 8'h7E);
            rd(2'd2, "modes_rx");
            check("modes_slave_rx_lit", q, 8'h81);
        end

        wrr(2'd0, 8'h00);
        rd(2'd3, "pre_ovr_status");
        for (int i = 0; i < 5; i++) mw[i] = 8'(i + 1);
        spi_run(5, 0);
        for (int i = 0; i < 5; i++) begin
            rd(2'd2, "ovr_rx");
            check("ovr_rx_lit", q, (i < 4) ? i + 1 : 0);
        end
        rd(2'd3, "ovr_status");
        check("ovr_set_lit", q[4], 1);
        rd(2'd3, "ovr_status2");
        check("ovr_clear_lit", q[4], 0);

        mw[0] = 8'h3C;
        spi_run(1, 0);
        check("unr_miso_zero", got_w[0], 8'h00);
        rd(2'd3, "unr_status");
        check("unr_set_lit", q[3], 1);
        wrr(2'd1, 8'h55);
        mw[0] = 8'h11; mw[1] = 8'h22;
        spi_run(2, 0);
        check("b2b_word1", got_w[0], 8'h55);
        check("b2b_word2", got_w[1], 8'h00);
        rd(2'd3, "b2b_status");
        check("b2b_unr_lit", q[3], 1);
        rd(2'd2, "drain_rx"); check("drain_lit0", q, 8'h3C);
        rd(2'd2, "drain_rx"); check("drain_lit1", q, 8'h11);
        rd(2'd2, "drain_rx"); check("drain_lit2", q, 8'h22);

        mw[0] = 8'hA3;
        spi_run(1, 3);
        rd(2'd3, "abort_status");
        check("abort_empty_lit", q[0], 1);
        mw[0] = 8'hF0;
        spi_run(1, 0);
        rd(2'd2, "after_abort_rx");
        check("after_abort_lit", q, 8'hF0);

        wrr(2'd0, 8'h01);
        wrr(2'd1, 8'h33);
        mw[0] = 8'h99;
        spi_run(1, 0);
        rd(2'd1, "tx_readback");
        check("tx_readback_lit", q, 8'h33);
        sclk = 1'b0;
        ss = 1'b1;
        repeat (8) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            repeat (HALF) @(posedge clk);
            sclk = 1'b0;
            repeat (HALF) @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0; ss = 1'b0; sclk = 1'b0; mosi = 1'b0;
        @(negedge clk);
        check("midrst_ack", ack, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_miso", miso, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
        rd(2'd0, "midrst_cfg");
        check("midrst_cfg_lit", q, 8'h00);
        rd(2'd3, "midrst_status");
        check("midrst_status_lit", q, 8'h01);
        rd(2'd2, "midrst_rx");
        check("midrst_rx_lit", q, 8'h00);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
